// File: rtl/me_pkg.sv
// Shared sizes, search-memory address map and controller states for the
// full-search motion estimator.
package me_pkg;
  localparam int BLK      = 16;
  localparam int RANGE    = 32;
  localparam int WIN_ROWS = 47;
  localparam int WIN_COLS = 51;
  localparam int BANK_W   = 17;

  localparam logic [7:0] BANK0_BASE = 8'd0;
  localparam logic [7:0] BANK1_BASE = 8'd47;
  localparam logic [7:0] BANK2_BASE = 8'd94;
  localparam logic [7:0] LAST_ADDR  = 8'd140;

  // LOAD spends one lead-in cycle, then one cycle per reference row.
  localparam int LOAD_LAST = BLK + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } me_state_e;
endpackage

// File: rtl/sad_row16.sv
// Sum of absolute differences across one 16-pixel row: per-pixel |a-b|
// followed by a four-level adder tree. Both rows share the same byte order.
module sad_row16
  import me_pkg::*;
(
  input  logic [8*BLK-1:0] ref_row_i,
  input  logic [8*BLK-1:0] win_row_i,
  output logic [11:0]      sad_o
);
  logic [7:0]  diff [BLK];
  logic [8:0]  lvl1 [BLK/2];
  logic [9:0]  lvl2 [BLK/4];
  logic [10:0] lvl3 [BLK/8];

  always_comb begin
    for (int c = 0; c < BLK; c++) begin
      if (ref_row_i[8*c +: 8] >= win_row_i[8*c +: 8]) begin
        diff[c] = ref_row_i[8*c +: 8] - win_row_i[8*c +: 8];
      end else begin
        diff[c] = win_row_i[8*c +: 8] - ref_row_i[8*c +: 8];
      end
    end
    for (int i = 0; i < BLK/2; i++) lvl1[i] = {1'b0, diff[2*i]} + {1'b0, diff[2*i+1]};
    for (int i = 0; i < BLK/4; i++) lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
    for (int i = 0; i < BLK/8; i++) lvl3[i] = {1'b0, lvl2[2*i]} + {1'b0, lvl2[2*i+1]};
    sad_o = {1'b0, lvl3[0]} + {1'b0, lvl3[1]};
  end
endmodule

// File: rtl/me_top_module.sv
// Full-search block matcher: 16x16 block against a 47x47 window, all 32x32
// displacements, one block row per cycle, strict-minimum SAD tracking.
module me_top_module
  import me_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [127:0] CurrentBlock,
  input  logic         WE_S,
  input  logic         WE_S2,
  input  logic [7:0]   WADDR_S,
  input  logic [135:0] WDATA_S,
  output logic         DE_out,
  output logic [15:0]  outSAD41,
  output logic [9:0]   positionSAD41,
  output logic [1:0]   dbg_state
);
  localparam int CNT_W = $clog2(RANGE * RANGE * BLK);

  me_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             stop_q;
  logic [15:0]      acc_q;
  logic [15:0]      best_sad_q;
  logic [9:0]       best_pos_q;
  logic             de_q;

  logic [8*BANK_W-1:0] bank0_q [WIN_ROWS];
  logic [8*BANK_W-1:0] bank1_q [WIN_ROWS];
  logic [8*BANK_W-1:0] bank2_q [WIN_ROWS];
  logic [8*BLK-1:0]    ref_q   [BLK];

  // Write decode: banks 0/1 need the extra qualifier, bank 2 does not.
  logic       wr0, wr1, wr2;
  logic [5:0] wrow;

  always_comb begin
    wr0  = 1'b0;
    wr1  = 1'b0;
    wr2  = 1'b0;
    wrow = 6'(WADDR_S - BANK0_BASE);
    if (WADDR_S < BANK1_BASE) begin
      wr0 = WE_S & WE_S2;
    end else if (WADDR_S < BANK2_BASE) begin
      wr1  = WE_S & WE_S2;
      wrow = 6'(WADDR_S - BANK1_BASE);
    end else if (WADDR_S <= LAST_ADDR) begin
      wr2  = WE_S;
      wrow = 6'(WADDR_S - BANK2_BASE);
    end
  end

  always_ff @(posedge clk) begin
    if (wr0) bank0_q[wrow] <= WDATA_S;
    if (wr1) bank1_q[wrow] <= WDATA_S;
    if (wr2) bank2_q[wrow] <= WDATA_S;
  end

  // Reference rows arrive one cycle after LOAD is entered, row r at count r+1.
  logic       load_row;
  logic [3:0] load_idx;

  assign load_row = (state_q == ST_LOAD) && !start &&
                    (cnt_q != '0) && (cnt_q <= CNT_W'(BLK));
  assign load_idx = 4'(cnt_q - 1'b1);

  always_ff @(posedge clk) begin
    if (load_row) ref_q[load_idx] <= CurrentBlock;
  end

  // Compute counter = {candidate k, row r}; k = {x, y} with y innermost.
  logic [9:0]          cand_k;
  logic [3:0]          row_idx;
  logic [4:0]          cand_x, cand_y;
  logic [5:0]          win_row;
  logic [8*WIN_COLS-1:0] row_bits;
  logic [8:0]          sel_hi;
  logic [8*BLK-1:0]    win_slice;
  logic [11:0]         row_sad;
  logic [15:0]         cand_sad;
  logic                last_row, last_cand;

  assign {cand_k, row_idx} = cnt_q;
  assign cand_x    = cand_k[9:5];
  assign cand_y    = cand_k[4:0];
  assign win_row   = {1'b0, cand_y} + {2'b00, row_idx};
  assign row_bits  = {bank0_q[win_row], bank1_q[win_row], bank2_q[win_row]};
  assign sel_hi    = 9'(8*WIN_COLS - 1) - {1'b0, cand_x, 3'b000};
  assign win_slice = row_bits[sel_hi -: 8*BLK];
  assign last_row  = (row_idx == 4'hF);
  assign last_cand = &cnt_q;
  assign cand_sad  = ((row_idx == 4'd0) ? 16'd0 : acc_q) + {4'd0, row_sad};

  sad_row16 u_sad_row16 (
    .ref_row_i (ref_q[row_idx]),
    .win_row_i (win_slice),
    .sad_o     (row_sad)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = ST_IDLE;
      ST_LOAD:    if (cnt_q == CNT_W'(LOAD_LAST)) state_d = ST_COMPUTE;
      ST_COMPUTE: if (stop_q || last_cand) state_d = ST_DONE;
      default:    state_d = state_q;
    endcase
    if (start) state_d = ST_LOAD;
  end

  // Stop is registered so a stop seen at one edge closes the search on the
  // next; the candidate in flight at that point is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      stop_q     <= 1'b0;
      acc_q      <= '0;
      best_sad_q <= '0;
      best_pos_q <= '0;
      de_q       <= 1'b0;
    end else begin
      stop_q <= stop && !start && (state_q == ST_COMPUTE);
      if (start) begin
        cnt_q      <= '0;
        best_sad_q <= 16'hFFFF;
        best_pos_q <= '0;
        de_q       <= 1'b0;
      end else if (state_q == ST_LOAD) begin
        cnt_q <= (cnt_q == CNT_W'(LOAD_LAST)) ? '0 : cnt_q + 1'b1;
      end else if (state_q == ST_COMPUTE) begin
        if (stop_q) begin
          de_q <= 1'b1;
        end else begin
          acc_q <= cand_sad;
          cnt_q <= cnt_q + 1'b1;
          if (last_row && (cand_sad < best_sad_q)) begin
            best_sad_q <= cand_sad;
            best_pos_q <= cand_k;
          end
          if (last_cand) de_q <= 1'b1;
        end
      end
    end
  end

  assign DE_out        = de_q;
  assign outSAD41      = best_sad_q;
  assign positionSAD41 = best_pos_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_me_top_module.sv
// Bench for me_top_module: loads windows through the write port, runs full
// searches and compares each result against a brute-force search model.
module tb_me_top_module;
  localparam int EXP_W = 58;  // {sad[15:0], pos[9:0], de_edge[31:0]}

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [127:0] CurrentBlock = '0;
  logic         WE_S = 1'b0;
  logic         WE_S2 = 1'b0;
  logic [7:0]   WADDR_S = '0;
  logic [135:0] WDATA_S = '0;
  logic         DE_out;
  logic [15:0]  outSAD41;
  logic [9:0]   positionSAD41;
  logic [1:0]   dbg_state;

  me_top_module dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .CurrentBlock  (CurrentBlock),
    .WE_S          (WE_S),
    .WE_S2         (WE_S2),
    .WADDR_S       (WADDR_S),
    .WDATA_S       (WDATA_S),
    .DE_out        (DE_out),
    .outSAD41      (outSAD41),
    .positionSAD41 (positionSAD41),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset / edge counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int pops = 0;
  logic [EXP_W-1:0] exp_q[$];

  logic [7:0] img   [47][51];  // picture to be loaded into the window
  logic [7:0] win_m [47][51];  // window as the write rules leave it
  logic [7:0] ref_m [16][16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_search(input int kmax, output int best_sad, output int best_pos);
    int x, y, s, a, b;
    best_sad = 65535;
    best_pos = 0;
    for (int k = 0; k < kmax; k++) begin
      x = k / 32;
      y = k % 32;
      s = 0;
      for (int r = 0; r < 16; r++) begin
        for (int c = 0; c < 16; c++) begin
          a = ref_m[r][c];
          b = win_m[y + r][x + c];
          s += (a > b) ? (a - b) : (b - a);
        end
      end
      if (s < best_sad) begin
        best_sad = s;
        best_pos = k;
      end
    end
  endtask

  // ---------------- drivers ----------------
  function automatic logic [135:0] pack_bank(input int row, input int bank);
    logic [135:0] d;
    for (int j = 0; j < 17; j++) d[135 - 8*j -: 8] = img[row][17*bank + j];
    return d;
  endfunction

  function automatic logic [127:0] pack_ref(input int r);
    logic [127:0] d;
    for (int c = 0; c < 16; c++) d[127 - 8*c -: 8] = ref_m[r][c];
    return d;
  endfunction

  task automatic mem_write(input int addr, input logic [135:0] data, input logic we2);
    int row, bank;
    @(negedge clk);
    WE_S    = 1'b1;
    WE_S2   = we2;
    WADDR_S = 8'(addr);
    WDATA_S = data;
    if (addr <= 140 && (addr >= 94 || we2)) begin
      bank = addr / 47;
      row  = addr % 47;
      for (int j = 0; j < 17; j++) win_m[row][17*bank + j] = data[135 - 8*j -: 8];
    end
  endtask

  task automatic bus_idle();
    @(negedge clk);
    WE_S  = 1'b0;
    WE_S2 = 1'b0;
  endtask

  task automatic load_image();
    for (int a = 0; a <= 140; a++) mem_write(a, pack_bank(a % 47, a / 47), 1'b1);
    bus_idle();
  endtask

  task automatic fill_img(input int v);
    for (int r = 0; r < 47; r++)
      for (int c = 0; c < 51; c++) img[r][c] = 8'(v);
  endtask

  task automatic place_ref(input int x, input int y);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) img[y + r][x + c] = ref_m[r][c];
  endtask

  task automatic run_mb(input string name, input int stop_after);
    int e_edge, s_edge, exp_edge, kmax, s, p, pops0;
    @(negedge clk);
    start = 1'b1;
    CurrentBlock = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    start = 1'b0;
    e_edge = cyc;
    pops0 = pops;
    check({name, "_de_cleared"}, 64'(DE_out), 64'd0);
    if (stop_after >= 0) begin
      s_edge   = e_edge + 18 + stop_after;
      exp_edge = s_edge + 1;
      kmax     = stop_after / 16;
    end else begin
      s_edge   = 0;
      exp_edge = e_edge + 16402;
      kmax     = 1024;
    end
    model_search(kmax, s, p);
    exp_q.push_back({16'(s), 10'(p), 32'(exp_edge)});
    @(negedge clk);
    for (int r = 0; r < 16; r++) begin
      CurrentBlock = pack_ref(r);
      @(negedge clk);
    end
    CurrentBlock = {$urandom, $urandom, $urandom, $urandom};
    if (stop_after >= 0) begin
      while (cyc < s_edge - 1) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end
    for (int i = 0; i < 17000 && pops == pops0; i++) @(negedge clk);
    if (pops == pops0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: DE_out not seen, expected at edge %0d", name, exp_edge);
    end
    repeat (3) @(negedge clk);
    check({name, "_hold_de"}, 64'(DE_out), 64'd1);
    check({name, "_hold_sad"}, 64'(outSAD41), 64'(s));
    check({name, "_hold_pos"}, 64'(positionSAD41), 64'(p));
  endtask

  // ---------------- monitor ----------------
  logic de_prev = 1'b0;
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (rst && DE_out && !de_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_de: DE_out rose at edge %0d with nothing expected", cyc);
      end else begin
        e = exp_q.pop_front();
        check("result_sad", 64'(outSAD41), 64'(e[57:42]));
        check("result_pos", 64'(positionSAD41), 64'(e[41:32]));
        check("result_de_edge", 64'(cyc), 64'(e[31:0]));
      end
      pops++;
    end
    de_prev = DE_out;
  end

  // ---------------- main sequence ----------------
  initial begin
    int gx, gy;
    logic [135:0] junk;

    // Reset held with all inputs toggling.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("reset_de", 64'(DE_out), 64'd0);
      check("reset_sad", 64'(outSAD41), 64'd0);
      check("reset_pos", 64'(positionSAD41), 64'd0);
      start        = 1'($urandom_range(0, 1));
      stop         = 1'($urandom_range(0, 1));
      WE_S         = 1'($urandom_range(0, 1));
      WE_S2        = 1'($urandom_range(0, 1));
      WADDR_S      = 8'($urandom_range(0, 255));
      WDATA_S      = {$urandom, $urandom, $urandom, $urandom, $urandom};
      CurrentBlock = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0; WE_S = 1'b0; WE_S2 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_de", 64'(DE_out), 64'd0);

    // Exact match at x=5,y=7, with a gated write to bank 0 and an out-of-range write.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) ref_m[r][c] = 8'(r*16 + c);
    fill_img(7);
    place_ref(5, 7);
    load_image();
    junk = {$urandom, $urandom, $urandom, $urandom, $urandom};
    mem_write(10, junk, 1'b0);
    mem_write(141 + $urandom_range(0, 114), junk, 1'b1);
    bus_idle();
    run_mb("exact", -1);
    check("exact_sad_zero", 64'(outSAD41), 64'd0);
    check("exact_pos_167", 64'(positionSAD41), 64'd167);

    // Ties: every candidate scores the same, the first one must win.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) ref_m[r][c] = 8'd100;
    fill_img(90);
    load_image();
    run_mb("ties", -1);
    check("ties_sad_2560", 64'(outSAD41), 64'd2560);
    check("ties_pos_0", 64'(positionSAD41), 64'd0);

    // Maximum possible SAD.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) ref_m[r][c] = 8'd255;
    fill_img(0);
    load_image();
    run_mb("max", -1);
    check("max_sad_65280", 64'(outSAD41), 64'd65280);

    // Early stop long before the match at x=31,y=31 is reached.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) ref_m[r][c] = 8'(r*16 + c);
    fill_img(7);
    place_ref(31, 31);
    load_image();
    run_mb("stop", 1000);
    check("stop_pos_not_1023", 64'(positionSAD41 != 10'd1023), 64'd1);

    // Random picture; the match sits across banks 1/2 and covers row 6, whose
    // bank-2 slice only reaches the window through a write with WE_S2 low.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) ref_m[r][c] = 8'($urandom_range(0, 255));
    for (int r = 0; r < 47; r++)
      for (int c = 0; c < 51; c++) img[r][c] = 8'($urandom_range(0, 255));
    gx = $urandom_range(19, 31);
    gy = $urandom_range(0, 6);
    place_ref(gx, gy);
    load_image();
    mem_write(100, {$urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1);
    mem_write(100, pack_bank(6, 2), 1'b0);
    bus_idle();
    run_mb("random", -1);
    check("random_sad_zero", 64'(outSAD41), 64'd0);
    check("random_pos", 64'(positionSAD41), 64'(gx*32 + gy));

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
